// File: rtl/fb_pkg.sv
// Framebuffer arbiter shared definitions.
//   FB_ADDR_W / PIX_W   : framebuffer address width and stored pixel width (RGB444)
//   FB_X_ORG / FB_Y_ORG : screen coordinates of the top-left corner of the 256x256 window
//   fb_state_t          : fill engine state
//   fb_wr_t             : one buffered engine write (address + pixel)
//   expand4to10         : widen a 4-bit colour channel to the 10-bit VGA DAC range
package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int PIX_W     = 12;
  localparam int FB_X_ORG  = 192;
  localparam int FB_Y_ORG  = 112;

  typedef enum logic {
    IDLE,
    CLEAR
  } fb_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [PIX_W-1:0]     data;
  } fb_wr_t;

  // Replicating the top bits spreads the 4-bit range evenly over 0..0x3FF.
  function automatic logic [9:0] expand4to10(input logic [3:0] c);
    return {c, c, c[3:2]};
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO buffering game-engine framebuffer writes.
//   iCLK, iRST_N : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write an entry; ignored while full
//   pop, pop_data   : pop_data shows the head entry; pop ignored while empty
//   full, empty, count : occupancy, all derived from the registered count
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       push,
  input  fb_wr_t                     push_data,
  input  logic                       pop,
  output fb_wr_t                     pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fb_wr_t            store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it was
  // pushed, so resetting it would add reset fan-out for no behavioural benefit.
  always_ff @(posedge iCLK) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer SRAM arbiter: VGA pixel fetch (highest priority), hardware fill
// engine, and FIFO-buffered game-engine writes share one single-port SRAM.
//   iCLK, iRST_N          : pixel clock, asynchronous active-low reset
//   vga_req, vga_x, vga_y : registered fetch request and screen coordinates
//   pix_r, pix_g, pix_b   : 10-bit colour to the VGA controller, 3 cycles after vga_req
//   wr_valid, wr_ready, wr_addr, wr_data : engine write port into the FIFO
//   clr_start, clr_color, clr_busy       : fill the whole framebuffer with one colour
//   mem_addr, mem_we, mem_wdata, mem_rdata : SRAM port (registered; read data 1 cycle late)
module fb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int X_ORG      = fb_pkg::FB_X_ORG,
  parameter int Y_ORG      = fb_pkg::FB_Y_ORG,
  parameter int PIX_W      = fb_pkg::PIX_W
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             vga_req,
  input  logic [12:0]      vga_x,
  input  logic [12:0]      vga_y,
  output logic [9:0]       pix_r,
  output logic [9:0]       pix_g,
  output logic [9:0]       pix_b,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [15:0]      wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             clr_start,
  input  logic [PIX_W-1:0] clr_color,
  output logic             clr_busy,
  output logic [15:0]      mem_addr,
  output logic             mem_we,
  output logic [PIX_W-1:0] mem_wdata,
  input  logic [PIX_W-1:0] mem_rdata
);

  import fb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  fb_state_t        state;
  logic [16:0]      fill_cnt;     // 17 bits so reaching 0xFFFF is distinct from wrapping
  logic [PIX_W-1:0] fill_color;
  logic             rd_v1;        // mem_addr currently carries a VGA read
  logic             rd_v2;        // mem_rdata currently carries VGA read data

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  fb_wr_t           fifo_head;
  logic [7:0]       win_x;
  logic [7:0]       win_y;

  // Subtract at full screen width, keep the low byte: off-window coordinates wrap.
  assign win_x = 8'(vga_x - 13'(X_ORG));
  assign win_y = 8'(vga_y - 13'(Y_ORG));

  assign wr_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  // The FIFO only drains on cycles that VGA and the fill engine both leave free.
  assign fifo_pop = !vga_req && (state == IDLE) && !fifo_empty;

  fb_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .push      (wr_valid && !fifo_full),
    .push_data ('{addr: wr_addr, data: wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      fill_color <= '0;
      clr_busy   <= 1'b0;
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      pix_r      <= '0;
      pix_g      <= '0;
      pix_b      <= '0;
    end else begin
      rd_v1 <= vga_req;
      rd_v2 <= rd_v1;
      if (rd_v2) begin
        pix_r <= expand4to10(mem_rdata[PIX_W-1 -: 4]);
        pix_g <= expand4to10(mem_rdata[PIX_W-5 -: 4]);
        pix_b <= expand4to10(mem_rdata[PIX_W-9 -: 4]);
      end

      // Port ownership, in priority order.
      if (vga_req) begin
        mem_addr <= {win_y, win_x};
        mem_we   <= 1'b0;
      end else if (state == CLEAR) begin
        mem_addr  <= fill_cnt[15:0];
        mem_we    <= 1'b1;
        mem_wdata <= fill_color;
      end else if (!fifo_empty) begin
        mem_addr  <= fifo_head.addr;
        mem_we    <= 1'b1;
        mem_wdata <= fifo_head.data;
      end else begin
        mem_we <= 1'b0;
      end

      // Fill engine. clr_busy trails the return to IDLE by one edge so it stays
      // high while the final fill write is on the bus.
      if (state == IDLE) begin
        clr_busy <= 1'b0;
        if (clr_start) begin
          state      <= CLEAR;
          fill_cnt   <= '0;
          fill_color <= clr_color;
          clr_busy   <= 1'b1;
        end
      end else if (!vga_req) begin
        fill_cnt <= fill_cnt + 17'd1;
        if (fill_cnt == 17'h0FFFF) state <= IDLE;
      end
    end
  end

endmodule
